alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Producer side of the adder hold register path.
- Latches the A-input (AI) and B-input (BI) operand registers from the internal buses, then performs one 6502 ALU operation per request.
- Presents the 8-bit result with a one-cycle result_valid strobe that serves as the adder hold register's load.
- Handles the NMOS decimal-mode adjust as an extra pipeline cycle, and reports the ACR, AVR and HC flags.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- sb_in  input  8  special bus value
- db_in  input  8  data bus value
- adl_in  input  8  address-low bus value
- ai_load_sb  input  1  load AI from sb_in
- ai_load_zero  input  1  load AI with 8'h00
- bi_load_db  input  1  load BI from db_in
- bi_load_db_inv  input  1  load BI from ~db_in
- bi_load_adl  input  1  load BI from adl_in
- op  input  3  operation code, alu_pkg::alu_op_t
- carry_in  input  1  carry into bit 0 (SUMS) or into bit 7 (SRS)
- decimal_en  input  1  BCD adjust for SUMS
- decimal_sub  input  1  with decimal_en: apply subtract adjust instead of add adjust
- op_valid  input  1  start operation this cycle
- busy  output  1  decimal adjust in progress; op_valid ignored
- result  output  8  ALU result, held until next result
- result_valid  output  1  one-cycle strobe; adder hold register load
- acr  output  1  carry out
- avr  output  1  signed overflow
- hc  output  1  half carry out of bit 3

Behaviour:
Operand registers
- AI and BI update at a clk edge when any of their load enables is high.
- AI priority: ai_load_zero > ai_load_sb.
- BI priority: bi_load_adl > bi_load_db_inv > bi_load_db.
- An op_valid in the same cycle as a load uses the pre-edge AI/BI values. A load and op_valid never interfere.

Operations, all on registered AI/BI
- SUMS: R = AI + BI + carry_in.
  - acr = bit 8 of the sum.
  - hc = carry out of bit 3 of AI[3:0] + BI[3:0] + carry_in.
  - avr = (AI^R)&(BI^R) bit 7, taken from the binary sum, including in decimal mode.
- ANDS, EORS, ORS: bitwise. acr = avr = hc = 0.
- SRS: R = {carry_in, (AI&BI)[7:1]}. acr = (AI&BI)[0]. avr = hc = 0.
- Undefined op codes: R = 8'h00, all flags 0, result_valid still strobes.

State machine (IDLE, DADJ)
- IDLE, op_valid=1, and not (SUMS && decimal_en):
  - Result and flags registered at edge N; result_valid=1 during cycle N+1.
  - Latency is 1.
  - Remain in IDLE.
- IDLE, op_valid=1, SUMS && decimal_en:
  - Binary sum, binary acr and hc captured into internal holding registers.
  - busy=1 during cycle N+1; go to DADJ.
- DADJ:
  - Unconditionally apply the adjust, register result and flags, strobe result_valid during cycle N+2, return to IDLE.
  - Latency is 2; busy=0 again in cycle N+2.
  - op_valid in DADJ is dropped: no queueing, no effect.
- Add adjust:
  - Low nibble += 6 if hc or low nibble > 9.
  - +0x60 if binary acr or adjusted value > 0x99 (compared before adding 0x60).
  - acr_out = binary acr OR high adjust applied.
- Subtract adjust:
  - Low nibble -= 6 (borrow not propagated to high nibble) if !hc.
  - -0x60 if !acr.
  - acr_out = binary acr.
- hc output in decimal mode is the binary hc. Wrap is modulo 256.

Output holding
- result and flags hold between results.
- result_valid is high for exactly one cycle per accepted op.

Reset
- result = 8'h00; acr = avr = hc = 0; result_valid = 0; busy = 0; AI = BI = 8'h00; state = IDLE.
- Reset during DADJ abandons the operation; no result_valid is issued.
- Reset has priority over loads and op_valid in the same cycle.

Decomposition:
- alu_pkg:
  - typedef enum logic [2:0] alu_op_t: SUMS=0, ANDS=1, EORS=2, ORS=3, SRS=4.
  - alu_state_t: IDLE, DADJ.
  - BCD constants: 4'h9, 8'h06, 8'h60.
- Sub-module alu_decimal_adjust, purely combinational:
  - Inputs: binary sum, acr, hc, decimal_sub.
  - Outputs: adjusted result, acr_out.
  - Instantiated once and unit-testable alone.

Test Plan:
- Load AI=0x50 via sb, BI=0x50 via db; SUMS, carry_in=0, decimal_en=0 -> next cycle result_valid=1, result=0xA0, avr=1, acr=0, hc=0.
- AI=0x15, BI=0x27, SUMS, decimal_en=1, carry_in=0 -> busy for 1 cycle; result_valid 2 cycles after op_valid; result=0x42, acr=0.
- AI=0x99, BI=0x01, SUMS decimal add, carry_in=0 -> result=0x00, acr=1. Second op_valid during busy produces no extra result_valid.
- AI=0x42, BI loaded via bi_load_db_inv with db=0x15, SUMS, carry_in=1, decimal_en=1, decimal_sub=1 -> result=0x27, acr=1.
- SRS with AI=0xFF, BI=0x03, carry_in=1 -> result=0x81, acr=1. Then ai_load_zero with ai_load_sb (sb=0x55) in the same cycle -> AI=0x00 confirmed by ORS with BI=0x0F giving 0x0F.
- Start decimal SUMS, assert reset in the DADJ cycle -> no result_valid; result=0x00, all flags 0, busy=0; next binary op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and BCD constants for the 6502 ALU core
package alu_pkg;

    typedef enum logic [2:0] {
        SUMS = 3'd0,
        ANDS = 3'd1,
        EORS = 3'd2,
        ORS  = 3'd3,
        SRS  = 3'd4
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        DADJ = 1'b1
    } alu_state_t;

    // Largest legal BCD digit and byte, and the two correction offsets
    localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;
    localparam logic [7:0] BCD_BYTE_MAX  = 8'h99;
    localparam logic [7:0] BCD_LOW_ADJ   = 8'h06;
    localparam logic [7:0] BCD_HIGH_ADJ  = 8'h60;

endpackage

// File: rtl/alu_decimal_adjust.sv
// rtl/alu_decimal_adjust.sv - NMOS 6502 BCD correction of a binary sum
module alu_decimal_adjust
    import alu_pkg::*;
(
    input  logic [7:0] sum,
    input  logic       acr,
    input  logic       hc,
    input  logic       decimal_sub,
    output logic [7:0] result,
    output logic       acr_out
);

    logic       low_fix;
    logic       high_fix;
    logic [8:0] add_low;
    logic [7:0] add_res;
    logic [7:0] sub_low;
    logic [7:0] sub_res;

    // Add path: the +6 step is kept 9 bits wide so a low-nibble carry that
    // pushes past 0xFF still forces the high correction.
    // Subtract path: the -6 stays inside the low nibble, no borrow upward.
    always_comb begin
        low_fix  = hc || (sum[3:0] > BCD_DIGIT_MAX);
        add_low  = {1'b0, sum} + (low_fix ? {1'b0, BCD_LOW_ADJ} : 9'h000);
        high_fix = acr || (add_low > {1'b0, BCD_BYTE_MAX});
        add_res  = add_low[7:0] + (high_fix ? BCD_HIGH_ADJ : 8'h00);

        sub_low  = hc ? sum : {sum[7:4], sum[3:0] - BCD_LOW_ADJ[3:0]};
        sub_res  = acr ? sub_low : (sub_low - BCD_HIGH_ADJ);

        result   = decimal_sub ? sub_res : add_res;
        acr_out  = decimal_sub ? acr : (acr | high_fix);
    end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 6502 ALU with operand latches, decimal adjust cycle and result strobe
module alu_core
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sb_in,
    input  logic [7:0] db_in,
    input  logic [7:0] adl_in,
    input  logic       ai_load_sb,
    input  logic       ai_load_zero,
    input  logic       bi_load_db,
    input  logic       bi_load_db_inv,
    input  logic       bi_load_adl,
    input  logic [2:0] op,
    input  logic       carry_in,
    input  logic       decimal_en,
    input  logic       decimal_sub,
    input  logic       op_valid,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       acr,
    output logic       avr,
    output logic       hc
);

    alu_state_t state;
    alu_op_t    op_e;

    logic [7:0] ai;
    logic [7:0] bi;

    logic [8:0] bin_sum;
    logic [4:0] low_sum;
    logic       bin_avr;
    logic [7:0] and_ab;

    logic [7:0] alu_r;
    logic       alu_acr;
    logic       alu_avr;
    logic       alu_hc;

    // Binary sum and flags parked for the decimal adjust cycle
    logic [7:0] hold_sum;
    logic       hold_acr;
    logic       hold_avr;
    logic       hold_hc;
    logic       hold_sub;

    logic [7:0] adj_result;
    logic       adj_acr;

    assign op_e = alu_op_t'(op);

    // Operand latches; priority zero > sb for AI, adl > ~db > db for BI
    always_ff @(posedge clk) begin
        if (reset) begin
            ai <= 8'h00;
            bi <= 8'h00;
        end else begin
            if (ai_load_zero)
                ai <= 8'h00;
            else if (ai_load_sb)
                ai <= sb_in;

            if (bi_load_adl)
                bi <= adl_in;
            else if (bi_load_db_inv)
                bi <= ~db_in;
            else if (bi_load_db)
                bi <= db_in;
        end
    end

    // One-cycle ALU function on the registered operands
    always_comb begin
        bin_sum = {1'b0, ai} + {1'b0, bi} + {8'h00, carry_in};
        low_sum = {1'b0, ai[3:0]} + {1'b0, bi[3:0]} + {4'h0, carry_in};
        bin_avr = (ai[7] ^ bin_sum[7]) & (bi[7] ^ bin_sum[7]);
        and_ab  = ai & bi;

        alu_r   = 8'h00;
        alu_acr = 1'b0;
        alu_avr = 1'b0;
        alu_hc  = 1'b0;
        case (op_e)
            SUMS: begin
                alu_r   = bin_sum[7:0];
                alu_acr = bin_sum[8];
                alu_avr = bin_avr;
                alu_hc  = low_sum[4];
            end
            ANDS: alu_r = and_ab;
            EORS: alu_r = ai ^ bi;
            ORS:  alu_r = ai | bi;
            SRS: begin
                alu_r   = {carry_in, and_ab[7:1]};
                alu_acr = and_ab[0];
            end
            default: alu_r = 8'h00;
        endcase
    end

    alu_decimal_adjust u_decimal_adjust (
        .sum         (hold_sum),
        .acr         (hold_acr),
        .hc          (hold_hc),
        .decimal_sub (hold_sub),
        .result      (adj_result),
        .acr_out     (adj_acr)
    );

    // Sequencer: single-cycle ops finish from IDLE, decimal SUMS detours through DADJ
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result       <= 8'h00;
            result_valid <= 1'b0;
            acr          <= 1'b0;
            avr          <= 1'b0;
            hc           <= 1'b0;
            hold_sum     <= 8'h00;
            hold_acr     <= 1'b0;
            hold_avr     <= 1'b0;
            hold_hc      <= 1'b0;
            hold_sub     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op_e == SUMS && decimal_en) begin
                            hold_sum <= alu_r;
                            hold_acr <= alu_acr;
                            hold_avr <= alu_avr;
                            hold_hc  <= alu_hc;
                            hold_sub <= decimal_sub;
                            busy     <= 1'b1;
                            state    <= DADJ;
                        end else begin
                            result       <= alu_r;
                            acr          <= alu_acr;
                            avr          <= alu_avr;
                            hc           <= alu_hc;
                            result_valid <= 1'b1;
                        end
                    end
                end
                DADJ: begin
                    // Any op_valid seen here is deliberately discarded
                    result       <= adj_result;
                    acr          <= adj_acr;
                    avr          <= hold_avr;
                    hc           <= hold_hc;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - randomized self-checking bench for alu_core against a reference model
module tb_alu_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sb_in, db_in, adl_in;
    logic       ai_load_sb, ai_load_zero;
    logic       bi_load_db, bi_load_db_inv, bi_load_adl;
    logic [2:0] op;
    logic       carry_in, decimal_en, decimal_sub, op_valid;
    logic       busy;
    logic [7:0] result;
    logic       result_valid, acr, avr, hc;

    int total = 0;
    int bad   = 0;

    // Model copies of the operand registers
    logic [7:0] m_ai = 8'h00;
    logic [7:0] m_bi = 8'h00;

    always #5 clk = ~clk;

    alu_core dut (
        .clk            (clk),
        .reset          (reset),
        .sb_in          (sb_in),
        .db_in          (db_in),
        .adl_in         (adl_in),
        .ai_load_sb     (ai_load_sb),
        .ai_load_zero   (ai_load_zero),
        .bi_load_db     (bi_load_db),
        .bi_load_db_inv (bi_load_db_inv),
        .bi_load_adl    (bi_load_adl),
        .op             (op),
        .carry_in       (carry_in),
        .decimal_en     (decimal_en),
        .decimal_sub    (decimal_sub),
        .op_valid       (op_valid),
        .busy           (busy),
        .result         (result),
        .result_valid   (result_valid),
        .acr            (acr),
        .avr            (avr),
        .hc             (hc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        ai_load_sb     = 1'b0;
        ai_load_zero   = 1'b0;
        bi_load_db     = 1'b0;
        bi_load_db_inv = 1'b0;
        bi_load_adl    = 1'b0;
        op_valid       = 1'b0;
        decimal_en     = 1'b0;
        decimal_sub    = 1'b0;
        carry_in       = 1'b0;
        op             = 3'd0;
    endtask

    // Apply whatever load enables were driven over the edge just taken
    task automatic update_regs();
        if (ai_load_zero)        m_ai = 8'h00;
        else if (ai_load_sb)     m_ai = sb_in;
        if (bi_load_adl)         m_bi = adl_in;
        else if (bi_load_db_inv) m_bi = ~db_in;
        else if (bi_load_db)     m_bi = db_in;
    endtask

    // Reference: returns {hc, avr, acr, result}, computed with integer arithmetic
    function automatic logic [10:0] ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                            input logic c, input logic d, input logic s);
        int sum, r, t, lo, hi, res;
        int ac, v, h;
        res = 0; ac = 0; v = 0; h = 0;
        case (o)
            3'd0: begin
                sum = int'(a) + int'(b) + int'(c);
                r   = sum % 256;
                ac  = (sum > 255) ? 1 : 0;
                h   = ((int'(a) % 16) + (int'(b) % 16) + int'(c) > 15) ? 1 : 0;
                v   = (((int'(a) >= 128) == (int'(b) >= 128)) && ((r >= 128) != (int'(a) >= 128))) ? 1 : 0;
                res = r;
                if (d && !s) begin
                    t = r;
                    if (h == 1 || r % 16 > 9) t = t + 6;
                    if (ac == 1 || t > 153) begin
                        t  = t + 96;
                        ac = 1;
                    end
                    res = t % 256;
                end else if (d && s) begin
                    lo = r % 16;
                    hi = r / 16;
                    if (h == 0) lo = (lo + 10) % 16;
                    res = hi * 16 + lo;
                    if (ac == 0) res = (res + 256 - 96) % 256;
                end
            end
            3'd1: res = int'(a & b);
            3'd2: res = int'(a ^ b);
            3'd3: res = int'(a | b);
            3'd4: begin
                t   = int'(a & b);
                res = int'(c) * 128 + t / 2;
                ac  = t % 2;
            end
            default: res = 0;
        endcase
        return {h[0], v[0], ac[0], 8'(res)};
    endfunction

    // Issue one op (loads may already be driven by the caller) and check its outcome
    task automatic do_op(input string tag, input logic [2:0] o, input logic c, input logic d,
                         input logic s, input bit poke);
        logic [10:0] exp;
        bit          dec;
        exp = ref_alu(o, m_ai, m_bi, c, d, s);
        dec = (o == 3'd0) && d;
        op = o; carry_in = c; decimal_en = d; decimal_sub = s; op_valid = 1'b1;
        tick();
        update_regs();
        clear_ctl();
        if (dec) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_early_rv"}, {31'd0, result_valid}, 32'd0);
            if (poke) begin
                op_valid = 1'b1;
                op = 3'($urandom_range(0, 4));
                carry_in = 1'($urandom);
            end
            tick();
            clear_ctl();
        end
        check({tag, "_rv"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_res"}, {24'd0, result}, {24'd0, exp[7:0]});
        check({tag, "_flags"}, {29'd0, hc, avr, acr}, {29'd0, exp[10:8]});
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_rv_once"}, {31'd0, result_valid}, 32'd0);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        sb_in = a; ai_load_sb = 1'b1;
        db_in = b; bi_load_db = 1'b1;
        tick();
        update_regs();
        clear_ctl();
    endtask

    initial begin
        reset = 1'b1;
        sb_in = 8'h00; db_in = 8'h00; adl_in = 8'h00;
        clear_ctl();
        tick();
        tick();
        check("rst_res", {24'd0, result}, 32'd0);
        check("rst_flags", {28'd0, busy, hc, avr, acr}, 32'd0);
        check("rst_rv", {31'd0, result_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // Binary add with signed overflow
        load(8'h50, 8'h50);
        do_op("t1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_lit", {21'd0, hc, avr, acr, result}, {21'd0, 3'b010, 8'hA0});

        // Decimal add
        load(8'h15, 8'h27);
        do_op("t2", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_lit", {23'd0, acr, result}, {23'd0, 1'b0, 8'h42});

        // Decimal add wrapping to zero, op_valid poked while busy
        load(8'h99, 8'h01);
        do_op("t3", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_lit", {23'd0, acr, result}, {23'd0, 1'b1, 8'h00});

        // Decimal subtract via inverted data bus
        sb_in = 8'h42; ai_load_sb = 1'b1;
        db_in = 8'h15; bi_load_db_inv = 1'b1;
        tick(); update_regs(); clear_ctl();
        do_op("t4", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_lit", {23'd0, acr, result}, {23'd0, 1'b1, 8'h27});

        // Shift right
        load(8'hFF, 8'h03);
        do_op("t5", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_lit", {23'd0, acr, result}, {23'd0, 1'b1, 8'h81});

        // Zero load beats sb load
        ai_load_zero = 1'b1; ai_load_sb = 1'b1; sb_in = 8'h55;
        bi_load_db = 1'b1; db_in = 8'h0F;
        tick(); update_regs(); clear_ctl();
        do_op("t6", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_lit", {24'd0, result}, 32'h0F);

        // Reset during the adjust cycle abandons the op
        load(8'h15, 8'h27);
        op = 3'd0; decimal_en = 1'b1; op_valid = 1'b1;
        tick(); clear_ctl();
        check("t7_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ai = 8'h00; m_bi = 8'h00;
        check("t7_rv", {31'd0, result_valid}, 32'd0);
        check("t7_state", {27'd0, busy, hc, avr, acr, 1'b0}, 32'd0);
        check("t7_res", {24'd0, result}, 32'd0);
        tick();
        check("t7_rv_late", {31'd0, result_valid}, 32'd0);
        load(8'h10, 8'h20);
        do_op("t7_next", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized ops with loads overlapping the op cycle
        for (int i = 0; i < 300; i++) begin
            sb_in  = 8'($urandom);
            db_in  = 8'($urandom);
            adl_in = 8'($urandom);
            ai_load_sb     = ($urandom_range(0, 2) == 0);
            ai_load_zero   = ($urandom_range(0, 4) == 0);
            bi_load_db     = ($urandom_range(0, 2) == 0);
            bi_load_db_inv = ($urandom_range(0, 3) == 0);
            bi_load_adl    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 0) begin
                tick(); update_regs(); clear_ctl();
            end
            do_op("rnd", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
